// File: rtl/free_list.sv
// Physical-register free list: a circular FIFO of free tags with two-wide allocate and release,
// plus per-checkpoint head snapshots so a mispredict restore returns speculative tags in one cycle.
module free_list #(
  parameter  int P_REGS = 64,
  parameter  int A_REGS = 32,
  parameter  int N_CKP  = 2,
  localparam int TAG_W  = $clog2(P_REGS),
  localparam int DEPTH  = P_REGS - A_REGS,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int PTR_W  = IDX_W + 1,
  localparam int CKP_W  = (N_CKP > 1) ? $clog2(N_CKP) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req_1,
  input  logic             alloc_req_2,
  output logic [TAG_W-1:0] alloc_tag_1,
  output logic [TAG_W-1:0] alloc_tag_2,
  output logic             alloc_ok,
  input  logic             release_en_1,
  input  logic             release_en_2,
  input  logic [TAG_W-1:0] release_tag_1,
  input  logic [TAG_W-1:0] release_tag_2,
  input  logic             ckp_en_a,
  input  logic             ckp_en_b,
  input  logic [CKP_W-1:0] ckp_id_a,
  input  logic [CKP_W-1:0] ckp_id_b,
  input  logic [1:0]       ckp_cnt_a,
  input  logic [1:0]       ckp_cnt_b,
  input  logic             restore_en,
  input  logic [CKP_W-1:0] restore_id,
  output logic [PTR_W-1:0] free_count
);

  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] fifo_q     [DEPTH];
  logic [TAG_W-1:0] fifo_d     [DEPTH];
  logic [PTR_W-1:0] ckp_head_q [N_CKP];
  logic [PTR_W-1:0] ckp_head_d [N_CKP];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] head_plus_req1;
  logic [PTR_W-1:0] tail_plus_rel1;
  logic [1:0]       need;
  logic [1:0]       n_rel;

  // The wrap bit keeps tail - head unambiguous: 0 means empty, DEPTH means full.
  assign free_count     = tail_q - head_q;
  assign need           = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
  assign n_rel          = {1'b0, release_en_1} + {1'b0, release_en_2};
  assign alloc_ok       = !restore_en && (free_count >= PTR_W'(need));
  assign head_plus_req1 = head_q + PTR_W'(alloc_req_1);
  assign tail_plus_rel1 = tail_q + PTR_W'(release_en_1);
  assign alloc_tag_1    = fifo_q[head_q[IDX_W-1:0]];
  assign alloc_tag_2    = fifo_q[head_plus_req1[IDX_W-1:0]];

  // NOTE: next-state logic uses blocking '=' with a default assigned first so no latch is
  // inferred; only the register process below uses non-blocking '<='.
  always_comb begin
    head_d = head_q;
    if (restore_en) begin
      head_d = ckp_head_q[restore_id];
    end else if (alloc_ok) begin
      head_d = head_q + PTR_W'(need);
    end
  end

  // Releases are never back-pressured, not even by a restore.
  always_comb begin
    fifo_d = fifo_q;
    if (release_en_1) fifo_d[tail_q[IDX_W-1:0]] = release_tag_1;
    if (release_en_2) fifo_d[tail_plus_rel1[IDX_W-1:0]] = release_tag_2;
    tail_d = tail_q + PTR_W'(n_rel);
  end

  // Slot b is written last so it wins when both target the same id.
  always_comb begin
    ckp_head_d = ckp_head_q;
    if (!restore_en) begin
      if (ckp_en_a) begin
        ckp_head_d[ckp_id_a] = head_q + (alloc_ok ? PTR_W'(ckp_cnt_a) : {PTR_W{1'b0}});
      end
      if (ckp_en_b) begin
        ckp_head_d[ckp_id_b] = head_q + (alloc_ok ? PTR_W'(ckp_cnt_b) : {PTR_W{1'b0}});
      end
    end
  end

  // NOTE: the FIFO storage is reset along with the pointers because its reset contents
  // (tags A_REGS..P_REGS-1) are the initial free set and are handed out right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= PTR_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= TAG_W'(A_REGS + i);
      for (int c = 0; c < N_CKP; c++) ckp_head_q[c] <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      fifo_q     <= fifo_d;
      ckp_head_q <= ckp_head_d;
    end
  end

  logic [CNT_W-1:0] count_after;
  logic [IDX_W-1:0] scan_off;
  logic             rel_dup;

  // Scan the live window [head, tail) for a tag that commit claims to be freeing again.
  always_comb begin
    count_after = {1'b0, free_count} + CNT_W'(n_rel) - (alloc_ok ? CNT_W'(need) : '0);
    scan_off    = '0;
    rel_dup     = release_en_1 && release_en_2 && (release_tag_1 == release_tag_2);
    for (int i = 0; i < DEPTH; i++) begin
      scan_off = IDX_W'(i) - head_q[IDX_W-1:0];
      if ((PTR_W'(scan_off) < free_count) &&
          ((release_en_1 && (fifo_q[i] == release_tag_1)) ||
           (release_en_2 && (fifo_q[i] == release_tag_2)))) begin
        rel_dup = 1'b1;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !restore_en |-> (count_after <= CNT_W'(DEPTH)));
  a_ckp_cnt_a: assert property (@(posedge clk) disable iff (!rst_n)
    (ckp_en_a && !restore_en) |-> (ckp_cnt_a <= need));
  a_ckp_cnt_b: assert property (@(posedge clk) disable iff (!rst_n)
    (ckp_en_b && !restore_en) |-> (ckp_cnt_b <= need));
  a_no_double_free: assert property (@(posedge clk) disable iff (!rst_n) !rel_dup);

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: a table of hand-derived cycles for the directed corner cases, then a
// randomized alloc/release run checked against a queue model of the free tags.
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_req_1, alloc_req_2;
  logic [5:0] alloc_tag_1, alloc_tag_2;
  logic       alloc_ok;
  logic       release_en_1, release_en_2;
  logic [5:0] release_tag_1, release_tag_2;
  logic       ckp_en_a, ckp_en_b;
  logic       ckp_id_a, ckp_id_b;
  logic [1:0] ckp_cnt_a, ckp_cnt_b;
  logic       restore_en;
  logic       restore_id;
  logic [5:0] free_count;

  always #5 clk = ~clk;

  free_list dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req_1  (alloc_req_1),
    .alloc_req_2  (alloc_req_2),
    .alloc_tag_1  (alloc_tag_1),
    .alloc_tag_2  (alloc_tag_2),
    .alloc_ok     (alloc_ok),
    .release_en_1 (release_en_1),
    .release_en_2 (release_en_2),
    .release_tag_1(release_tag_1),
    .release_tag_2(release_tag_2),
    .ckp_en_a     (ckp_en_a),
    .ckp_en_b     (ckp_en_b),
    .ckp_id_a     (ckp_id_a),
    .ckp_id_b     (ckp_id_b),
    .ckp_cnt_a    (ckp_cnt_a),
    .ckp_cnt_b    (ckp_cnt_b),
    .restore_en   (restore_en),
    .restore_id   (restore_id),
    .free_count   (free_count)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       r1, r2;
    logic       e1;
    logic [5:0] t1;
    logic       e2;
    logic [5:0] t2;
    logic       ca, ia;
    logic [1:0] na;
    logic       cb, ib;
    logic [1:0] nb;
    logic       rs, ri;
    logic       x_ok;
    logic [5:0] x_t1, x_t2, x_cnt;
  } vec_t;

  typedef struct {
    string      name;
    logic       ok;
    logic       chk1, chk2;
    logic [5:0] t1, t2, cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t row(input string name, input logic r1, input logic r2,
                               input logic x_ok, input int x_t1, input int x_t2, input int x_cnt);
    vec_t v;
    v.name = name; v.rst = 1'b0; v.r1 = r1; v.r2 = r2;
    v.e1 = 1'b0; v.t1 = '0; v.e2 = 1'b0; v.t2 = '0;
    v.ca = 1'b0; v.ia = 1'b0; v.na = '0; v.cb = 1'b0; v.ib = 1'b0; v.nb = '0;
    v.rs = 1'b0; v.ri = 1'b0;
    v.x_ok = x_ok; v.x_t1 = 6'(x_t1); v.x_t2 = 6'(x_t2); v.x_cnt = 6'(x_cnt);
    return v;
  endfunction

  function automatic vec_t with_reset(input vec_t v);
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic vec_t with_rel(input vec_t v, input logic e1, input int t1,
                                    input logic e2, input int t2);
    v.e1 = e1; v.t1 = 6'(t1); v.e2 = e2; v.t2 = 6'(t2);
    return v;
  endfunction

  function automatic vec_t with_ckp(input vec_t v, input logic ca, input logic ia, input int na,
                                    input logic cb, input logic ib, input int nb);
    v.ca = ca; v.ia = ia; v.na = 2'(na); v.cb = cb; v.ib = ib; v.nb = 2'(nb);
    return v;
  endfunction

  function automatic vec_t with_restore(input vec_t v, input logic ri);
    v.rs = 1'b1; v.ri = ri;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    alloc_req_1   = v.r1;
    alloc_req_2   = v.r2;
    release_en_1  = v.e1;
    release_tag_1 = v.t1;
    release_en_2  = v.e2;
    release_tag_2 = v.t2;
    ckp_en_a      = v.ca;
    ckp_id_a      = v.ia;
    ckp_cnt_a     = v.na;
    ckp_en_b      = v.cb;
    ckp_id_b      = v.ib;
    ckp_cnt_b     = v.nb;
    restore_en    = v.rs;
    restore_id    = v.ri;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(row("idle", 1'b0, 1'b0, 1'b1, 0, 0, 0));
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    next_cycle();
  endtask

  // Outputs are sampled on the falling edge, half a cycle after the inputs settle.
  task automatic sample_and_compare();
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: no expected entry, got free_count %0d", free_count);
    end else begin
      e = exp_q.pop_front();
      check({e.name, " alloc_ok"}, alloc_ok, e.ok);
      check({e.name, " free_count"}, free_count, e.cnt);
      if (e.ok && e.chk1) check({e.name, " alloc_tag_1"}, alloc_tag_1, e.t1);
      if (e.ok && e.chk2) check({e.name, " alloc_tag_2"}, alloc_tag_2, e.t2);
    end
  endtask

  task automatic build_table();
    vec_t v;
    for (int k = 0; k < 16; k++) begin
      v = row($sformatf("drain%0d", k), 1'b1, 1'b1, 1'b1, 32 + 2 * k, 33 + 2 * k, 32 - 2 * k);
      if (k == 0) v = with_reset(v);
      vecs.push_back(v);
    end
    vecs.push_back(row("empty_both", 1'b1, 1'b1, 1'b0, 0, 0, 0));
    vecs.push_back(with_rel(row("rel3", 1'b0, 1'b0, 1'b1, 0, 0, 0), 1'b1, 3, 1'b0, 0));
    vecs.push_back(row("one_free_both", 1'b1, 1'b1, 1'b0, 0, 0, 1));
    vecs.push_back(with_rel(row("rel5", 1'b0, 1'b0, 1'b1, 0, 0, 1), 1'b1, 5, 1'b0, 0));
    vecs.push_back(row("two_free_both", 1'b1, 1'b1, 1'b1, 3, 5, 2));
    vecs.push_back(row("after_two", 1'b0, 1'b0, 1'b1, 0, 0, 0));
    vecs.push_back(with_rel(row("rel7_9", 1'b0, 1'b0, 1'b1, 0, 0, 0), 1'b1, 7, 1'b1, 9));
    vecs.push_back(row("lone_req2", 1'b0, 1'b1, 1'b1, 0, 7, 2));
    vecs.push_back(row("lone_req1", 1'b1, 1'b0, 1'b1, 9, 0, 1));
    vecs.push_back(row("drained", 1'b0, 1'b0, 1'b1, 0, 0, 0));

    vecs.push_back(with_reset(with_ckp(row("ckp0_alloc", 1'b1, 1'b1, 1'b1, 32, 33, 32),
                                       1'b1, 1'b0, 1, 1'b0, 1'b0, 0)));
    vecs.push_back(row("alloc34", 1'b1, 1'b1, 1'b1, 34, 35, 30));
    vecs.push_back(row("alloc36", 1'b1, 1'b1, 1'b1, 36, 37, 28));
    vecs.push_back(row("alloc38", 1'b1, 1'b1, 1'b1, 38, 39, 26));
    vecs.push_back(with_restore(row("restore0", 1'b0, 1'b0, 1'b0, 0, 0, 24), 1'b0));
    vecs.push_back(row("post_restore0", 1'b1, 1'b0, 1'b1, 33, 0, 31));
    vecs.push_back(row("post_restore0_idle", 1'b0, 1'b0, 1'b1, 0, 0, 30));

    vecs.push_back(with_reset(with_ckp(row("dual_ckp", 1'b1, 1'b1, 1'b1, 32, 33, 32),
                                       1'b1, 1'b0, 1, 1'b1, 1'b1, 2)));
    vecs.push_back(row("dual_alloc", 1'b1, 1'b1, 1'b1, 34, 35, 30));
    vecs.push_back(with_restore(row("restore1", 1'b0, 1'b0, 1'b0, 0, 0, 28), 1'b1));
    vecs.push_back(row("post_restore1", 1'b1, 1'b0, 1'b1, 34, 0, 30));
    vecs.push_back(with_restore(row("restore0_late", 1'b0, 1'b0, 1'b0, 0, 0, 29), 1'b0));
    vecs.push_back(row("post_restore0_late", 1'b1, 1'b0, 1'b1, 33, 0, 31));
    vecs.push_back(row("dual_idle", 1'b0, 1'b0, 1'b1, 0, 0, 30));

    vecs.push_back(with_reset(row("rr_alloc", 1'b1, 1'b1, 1'b1, 32, 33, 32)));
    vecs.push_back(with_ckp(row("rr_ckp", 1'b1, 1'b0, 1'b1, 34, 0, 30),
                            1'b1, 1'b1, 1, 1'b1, 1'b0, 0));
    vecs.push_back(row("rr_alloc35", 1'b1, 1'b1, 1'b1, 35, 36, 29));
    vecs.push_back(with_ckp(with_rel(with_restore(row("rr_restore", 1'b1, 1'b1, 1'b0, 0, 0, 27),
                                                  1'b1), 1'b1, 7, 1'b0, 0),
                            1'b1, 1'b0, 2, 1'b0, 1'b0, 0));
    vecs.push_back(row("rr_after", 1'b1, 1'b1, 1'b1, 35, 36, 30));
    vecs.push_back(with_restore(row("rr_restore0", 1'b0, 1'b0, 1'b0, 0, 0, 28), 1'b0));
    vecs.push_back(row("rr_post", 1'b1, 1'b0, 1'b1, 34, 0, 31));

    vecs.push_back(with_reset(with_ckp(row("same_id", 1'b1, 1'b1, 1'b1, 32, 33, 32),
                                       1'b1, 1'b1, 0, 1'b1, 1'b1, 2)));
    vecs.push_back(row("same_id_alloc", 1'b1, 1'b1, 1'b1, 34, 35, 30));
    vecs.push_back(with_restore(row("same_id_restore", 1'b0, 1'b0, 1'b0, 0, 0, 28), 1'b1));
    vecs.push_back(row("same_id_post", 1'b1, 1'b0, 1'b1, 34, 0, 30));
  endtask

  task automatic run_table();
    exp_t e;
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i]);
      e.name = vecs[i].name;
      e.ok   = vecs[i].x_ok;
      e.chk1 = vecs[i].r1;
      e.chk2 = vecs[i].r2;
      e.t1   = vecs[i].x_t1;
      e.t2   = vecs[i].x_t2;
      e.cnt  = vecs[i].x_cnt;
      exp_q.push_back(e);
      sample_and_compare();
      next_cycle();
    end
  endtask

  // Random traffic through several pointer wraps; commit only frees tags that are in use.
  task automatic random_phase();
    int   free_q[$];
    int   busy[$];
    bit   in_use[64];
    int   popped;
    int   need, pop, room, idx;
    vec_t v;
    exp_t e;
    popped = 0;
    do_reset();
    for (int i = 0; i < 64; i++) in_use[i] = (i < 32);
    for (int i = 0; i < 32; i++) begin
      busy.push_back(i);
      free_q.push_back(32 + i);
    end
    for (int cyc = 0; cyc < 4000 && popped < 3 * 64; cyc++) begin
      v = row($sformatf("wrap%0d", cyc), 1'b0, 1'b0, 1'b1, 0, 0, 0);
      v.r1 = ($urandom_range(0, 3) != 0);
      v.r2 = ($urandom_range(0, 3) != 0);
      need = int'(v.r1) + int'(v.r2);
      e.name = v.name;
      e.ok   = (free_q.size() >= need);
      e.chk1 = v.r1;
      e.chk2 = v.r2;
      e.cnt  = 6'(free_q.size());
      e.t1   = (e.ok && v.r1) ? 6'(free_q[0]) : 6'd0;
      e.t2   = (e.ok && v.r2) ? 6'(free_q[v.r1 ? 1 : 0]) : 6'd0;
      pop    = e.ok ? need : 0;
      room   = 32 - (free_q.size() - pop);
      if (room >= 1 && $urandom_range(0, 3) != 0) begin
        idx = $urandom_range(0, busy.size() - 1);
        v.e1 = 1'b1;
        v.t1 = 6'(busy[idx]);
        busy.delete(idx);
        room--;
      end
      if (room >= 1 && $urandom_range(0, 3) != 0) begin
        idx = $urandom_range(0, busy.size() - 1);
        v.e2 = 1'b1;
        v.t2 = 6'(busy[idx]);
        busy.delete(idx);
      end
      drive(v);
      exp_q.push_back(e);
      sample_and_compare();
      if (alloc_ok && v.r1) begin
        check({v.name, " tag_1 not already allocated"}, int'(in_use[alloc_tag_1]), 0);
        in_use[alloc_tag_1] = 1'b1;
      end
      if (alloc_ok && v.r2) begin
        check({v.name, " tag_2 not already allocated"}, int'(in_use[alloc_tag_2]), 0);
        in_use[alloc_tag_2] = 1'b1;
      end
      for (int k = 0; k < pop; k++) busy.push_back(free_q.pop_front());
      if (v.e1) begin
        free_q.push_back(int'(v.t1));
        in_use[v.t1] = 1'b0;
      end
      if (v.e2) begin
        free_q.push_back(int'(v.t2));
        in_use[v.t2] = 1'b0;
      end
      popped += pop;
      next_cycle();
    end
    drive(row("idle", 1'b0, 1'b0, 1'b1, 0, 0, 0));
    e.name = "wrap_final";
    e.ok   = 1'b1;
    e.chk1 = 1'b0;
    e.chk2 = 1'b0;
    e.t1   = '0;
    e.t2   = '0;
    e.cnt  = 6'(free_q.size());
    exp_q.push_back(e);
    sample_and_compare();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(row("idle", 1'b0, 1'b0, 1'b1, 0, 0, 0));
    build_table();
    next_cycle();
    run_table();
    random_phase();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
